csr_port_arb: RTL and testbench

CSR_PORT_ARB -- requirements
Module: csr_port_arb

---
 rtl/csr_port_arb_pkg.sv | 25 ++
 rtl/csr_port_arb_if.sv | 54 +++++
 rtl/csr_port_arb_rmw.sv | 33 +++
 rtl/csr_port_arb.sv | 171 +++++++++++++++++
 tb/tb_csr_port_arb.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_port_arb_pkg.sv
// Shared widths, CSR op codes and arbiter state encoding for csr_port_arb.
// CSR_ARB_DBG_EN adds the debug state S_D.
package csr_port_arb_pkg;

  localparam int BUS_CSR_IMM  = 12;
  localparam int BUS_DATA_REG = 64;

  localparam logic [1:0] CSR_OP_RO = 2'b00;
  localparam logic [1:0] CSR_OP_RW = 2'b01;
  localparam logic [1:0] CSR_OP_RS = 2'b10;
  localparam logic [1:0] CSR_OP_RC = 2'b11;

  localparam logic [BUS_CSR_IMM-1:0] CSR_ADDR_ZERO = 12'h000;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_TRAP = 5'b00010,
    S_E_RD = 5'b00100,
    S_E_WR = 5'b01000
`ifdef CSR_ARB_DBG_EN
    , S_D  = 5'b10000
`endif
  } arb_state_e;

endpackage

// File: rtl/csr_port_arb_if.sv
// Requester and CSR-file signals of csr_port_arb; slave = arbiter side, master = requesters/CSR file.
// Debug signals exist only when CSR_ARB_DBG_EN is defined.
interface csr_port_arb_if;
  import csr_port_arb_pkg::*;

  logic                    t_req;
  logic                    t_lock;
  logic [BUS_CSR_IMM-1:0]  t_addr;
  logic [BUS_DATA_REG-1:0] t_wdata;
  logic                    t_gnt;

  logic                    e_req;
  logic [1:0]              e_op;
  logic [BUS_CSR_IMM-1:0]  e_addr;
  logic [BUS_DATA_REG-1:0] e_wdata;
  logic                    e_ack;
  logic                    e_done;
  logic [BUS_DATA_REG-1:0] e_rdata;
  logic                    e_busy;
  logic                    flush_i;

  logic                    csr_we_o;
  logic [BUS_CSR_IMM-1:0]  csr_addr_o;
  logic [BUS_DATA_REG-1:0] csr_data_o;
  logic [BUS_DATA_REG-1:0] csr_data_i;

`ifdef CSR_ARB_DBG_EN
  logic                    d_req;
  logic                    d_we;
  logic [BUS_CSR_IMM-1:0]  d_addr;
  logic [BUS_DATA_REG-1:0] d_wdata;
  logic                    d_ack;
  logic [BUS_DATA_REG-1:0] d_rdata;
`endif

  modport slave (
    input  t_req, t_lock, t_addr, t_wdata, e_req, e_op, e_addr, e_wdata, flush_i, csr_data_i,
`ifdef CSR_ARB_DBG_EN
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_rdata,
`endif
    output t_gnt, e_ack, e_done, e_rdata, e_busy, csr_we_o, csr_addr_o, csr_data_o
  );

  modport master (
    output t_req, t_lock, t_addr, t_wdata, e_req, e_op, e_addr, e_wdata, flush_i, csr_data_i,
`ifdef CSR_ARB_DBG_EN
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_rdata,
`endif
    input  t_gnt, e_ack, e_done, e_rdata, e_busy, csr_we_o, csr_addr_o, csr_data_o
  );

endinterface

// File: rtl/csr_port_arb_rmw.sv
// csr_rmw: combinational new-value and skip-write decision for EX CSR instructions.
module csr_rmw
  import csr_port_arb_pkg::*;
(
  input  logic [1:0]              op_i,
  input  logic [BUS_DATA_REG-1:0] old_i,
  input  logic [BUS_DATA_REG-1:0] wdata_i,
  output logic [BUS_DATA_REG-1:0] new_o,
  output logic                    skip_o
);

  logic wdata_zero_s;
  assign wdata_zero_s = (wdata_i == {BUS_DATA_REG{1'b0}});

  always_comb begin
    new_o  = old_i;
    skip_o = 1'b0;
    case (op_i)
      CSR_OP_RO: skip_o = 1'b1;
      CSR_OP_RW: new_o  = wdata_i;
      CSR_OP_RS: begin
        new_o  = old_i | wdata_i;
        skip_o = wdata_zero_s;
      end
      CSR_OP_RC: begin
        new_o  = old_i & ~wdata_i;
        skip_o = wdata_zero_s;
      end
      default: skip_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/csr_port_arb.sv
// csr_port_arb: single CSR-file port shared by trap writes, EX CSR read-modify-writes
// and (with CSR_ARB_DBG_EN) debug accesses. Priority trap > EX > debug, no preemption.
module csr_port_arb
  import csr_port_arb_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  csr_port_arb_if.slave  bus
);

  arb_state_e              state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [BUS_CSR_IMM-1:0]  addr_q, addr_d;
  logic [BUS_DATA_REG-1:0] wdata_q, wdata_d;
  logic [BUS_DATA_REG-1:0] new_q, new_d;
  logic [BUS_DATA_REG-1:0] rdata_q, rdata_d;
  logic                    done_q, done_d;
`ifdef CSR_ARB_DBG_EN
  logic                    d_ack_q, d_ack_d;
  logic [BUS_DATA_REG-1:0] d_rdata_q, d_rdata_d;
`endif

  logic                    t_gnt_s, e_ack_s, we_s;
  logic [BUS_CSR_IMM-1:0]  port_addr_s;
  logic [BUS_DATA_REG-1:0] port_data_s;
  logic [BUS_DATA_REG-1:0] rmw_new_s;
  logic                    rmw_skip_s;

  csr_rmw u_rmw (
    .op_i    (op_q),
    .old_i   (bus.csr_data_i),
    .wdata_i (wdata_q),
    .new_o   (rmw_new_s),
    .skip_o  (rmw_skip_s)
  );

  // Same-cycle grants depend on live requests, so they are forced low while rst is held.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    new_d       = new_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    t_gnt_s     = 1'b0;
    e_ack_s     = 1'b0;
    we_s        = 1'b0;
    port_addr_s = CSR_ADDR_ZERO;
    port_data_s = {BUS_DATA_REG{1'b0}};
`ifdef CSR_ARB_DBG_EN
    d_ack_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
`endif
    if (rst) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.t_req) begin
            t_gnt_s     = 1'b1;
            we_s        = 1'b1;
            port_addr_s = bus.t_addr;
            port_data_s = bus.t_wdata;
            state_d     = bus.t_lock ? S_TRAP : S_IDLE;
          end else if (bus.e_req) begin
            e_ack_s = 1'b1;
            op_d    = bus.e_op;
            addr_d  = bus.e_addr;
            wdata_d = bus.e_wdata;
            state_d = S_E_RD;
          end
`ifdef CSR_ARB_DBG_EN
          else if (bus.d_req && !d_ack_q) begin
            state_d = S_D;
          end
`endif
          else begin
            state_d = S_IDLE;
          end
        end
        S_TRAP: begin
          if (bus.t_req) begin
            t_gnt_s     = 1'b1;
            we_s        = 1'b1;
            port_addr_s = bus.t_addr;
            port_data_s = bus.t_wdata;
            state_d     = bus.t_lock ? S_TRAP : S_IDLE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_E_RD: begin
          port_addr_s = addr_q;
          if (bus.flush_i) begin
            state_d = S_IDLE;
          end else begin
            rdata_d = bus.csr_data_i;
            new_d   = rmw_new_s;
            if (rmw_skip_s) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_E_WR;
            end
          end
        end
        S_E_WR: begin
          we_s        = 1'b1;
          port_addr_s = addr_q;
          port_data_s = new_q;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end
`ifdef CSR_ARB_DBG_EN
        S_D: begin
          we_s        = bus.d_we;
          port_addr_s = bus.d_addr;
          port_data_s = bus.d_wdata;
          d_rdata_d   = bus.csr_data_i;
          d_ack_d     = 1'b1;
          state_d     = S_IDLE;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 2'b00;
      addr_q    <= CSR_ADDR_ZERO;
      wdata_q   <= {BUS_DATA_REG{1'b0}};
      new_q     <= {BUS_DATA_REG{1'b0}};
      rdata_q   <= {BUS_DATA_REG{1'b0}};
      done_q    <= 1'b0;
`ifdef CSR_ARB_DBG_EN
      d_ack_q   <= 1'b0;
      d_rdata_q <= {BUS_DATA_REG{1'b0}};
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      new_q     <= new_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
`ifdef CSR_ARB_DBG_EN
      d_ack_q   <= d_ack_d;
      d_rdata_q <= d_rdata_d;
`endif
    end
  end

  assign bus.t_gnt      = t_gnt_s;
  assign bus.e_ack      = e_ack_s;
  assign bus.e_done     = done_q;
  assign bus.e_rdata    = rdata_q;
  assign bus.e_busy     = (state_q == S_E_RD) || (state_q == S_E_WR);
  assign bus.csr_we_o   = we_s;
  assign bus.csr_addr_o = port_addr_s;
  assign bus.csr_data_o = port_data_s;
`ifdef CSR_ARB_DBG_EN
  assign bus.d_ack      = d_ack_q;
  assign bus.d_rdata    = d_rdata_q;
`endif

endmodule

// File: tb/tb_csr_port_arb.sv
// Self-checking bench for csr_port_arb: cycle checks per scenario plus a write/completion scoreboard.
// Define CSR_ARB_DBG_EN to also exercise the debug port.
module tb_csr_port_arb;
  import csr_port_arb_pkg::*;

  typedef struct packed {
    logic [11:0] a;
    logic [63:0] d;
  } wr_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  wr_t         exp_wr[$];
  wr_t         wr_seen[$];
  logic [63:0] exp_done[$];
  logic [63:0] done_seen[$];
  logic [63:0] model_mem [int];
  logic [63:0] csr_mem [0:4095];

  csr_port_arb_if bus();

  csr_port_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.csr_we_o) csr_mem[bus.csr_addr_o] <= bus.csr_data_o;
  end
  assign bus.csr_data_i = csr_mem[bus.csr_addr_o];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.csr_we_o) wr_seen.push_back({bus.csr_addr_o, bus.csr_data_o});
      if (bus.e_done)   done_seen.push_back(bus.e_rdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [63:0] d);
    exp_wr.push_back({a, d});
    model_mem[int'(a)] = d;
  endtask

  task automatic idle_inputs();
    bus.t_req   = 1'b0;
    bus.t_lock  = 1'b0;
    bus.t_addr  = 12'h000;
    bus.t_wdata = 64'h0;
    bus.e_req   = 1'b0;
    bus.e_op    = 2'b00;
    bus.e_addr  = 12'h000;
    bus.e_wdata = 64'h0;
    bus.flush_i = 1'b0;
`ifdef CSR_ARB_DBG_EN
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 12'h000;
    bus.d_wdata = 64'h0;
`endif
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.t_req = 1'b1;
    bus.e_req = 1'b1;
    #13;
    total++;
    if ({bus.t_gnt, bus.e_ack, bus.e_done, bus.e_busy, bus.csr_we_o} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_ctl: got gnt/ack/done/busy/we=%b want 00000",
               {bus.t_gnt, bus.e_ack, bus.e_done, bus.e_busy, bus.csr_we_o});
    end
    total++;
    if (bus.csr_addr_o !== 12'h000 || bus.csr_data_o !== 64'h0 || bus.e_rdata !== 64'h0) begin
      bad++;
      $display("FAIL reset_data: got addr=%h data=%h rdata=%h want all 0",
               bus.csr_addr_o, bus.csr_data_o, bus.e_rdata);
    end
    idle_inputs();
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    total++;
    if (bus.csr_we_o !== 1'b0 || bus.csr_addr_o !== 12'h000 || bus.e_busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_port: got we=%b addr=%h busy=%b want 0/000/0",
               bus.csr_we_o, bus.csr_addr_o, bus.e_busy);
    end
  endtask

  task automatic test_trap_burst();
    logic [11:0] addrs [3];
    logic [63:0] datas [3];
    addrs[0] = 12'h341; datas[0] = 64'hA5A5_0000_0000_0341;
    addrs[1] = 12'h342; datas[1] = 64'hB6B6_0000_0000_0342;
    addrs[2] = 12'h300; datas[2] = 64'hC7C7_0000_0000_0300;
    for (int i = 0; i < 3; i++) begin
      step();
      bus.t_req   = 1'b1;
      bus.t_lock  = (i < 2) ? 1'b1 : 1'b0;
      bus.t_addr  = addrs[i];
      bus.t_wdata = datas[i];
      push_wr(addrs[i], datas[i]);
      @(negedge clk);
      total++;
      if (bus.t_gnt !== 1'b1 || bus.csr_we_o !== 1'b1 || bus.csr_addr_o !== addrs[i]) begin
        bad++;
        $display("FAIL trap_burst[%0d]: got gnt=%b we=%b addr=%h want 1/1/%h",
                 i, bus.t_gnt, bus.csr_we_o, bus.csr_addr_o, addrs[i]);
      end
    end
    step();
    idle_inputs();
    @(negedge clk);
    total++;
    if (bus.t_gnt !== 1'b0 || bus.csr_we_o !== 1'b0 || bus.csr_data_o !== 64'h0) begin
      bad++;
      $display("FAIL trap_release: got gnt=%b we=%b data=%h want 0/0/0",
               bus.t_gnt, bus.csr_we_o, bus.csr_data_o);
    end
  endtask

  task automatic test_rs();
    logic [63:0] exp_new;
    step();
    bus.t_req = 1'b1; bus.t_addr = 12'h304; bus.t_wdata = 64'h80;
    push_wr(12'h304, 64'h80);
    step();
    idle_inputs();
    bus.e_req = 1'b1; bus.e_op = CSR_OP_RS; bus.e_addr = 12'h304; bus.e_wdata = 64'h800;
    @(negedge clk);
    total++;
    if (bus.e_ack !== 1'b1 || bus.csr_we_o !== 1'b0 || bus.csr_addr_o !== 12'h000) begin
      bad++;
      $display("FAIL rs_accept: got ack=%b we=%b addr=%h want 1/0/000", bus.e_ack, bus.csr_we_o, bus.csr_addr_o);
    end
    step();
    idle_inputs();
    @(negedge clk);
    total++;
    if (bus.e_busy !== 1'b1 || bus.csr_we_o !== 1'b0 || bus.csr_addr_o !== 12'h304) begin
      bad++;
      $display("FAIL rs_read: got busy=%b we=%b addr=%h want 1/0/304", bus.e_busy, bus.csr_we_o, bus.csr_addr_o);
    end
    exp_done.push_back(model_mem[int'(12'h304)]);
    exp_new = model_mem[int'(12'h304)] | 64'h800;
    push_wr(12'h304, exp_new);
    step();
    @(negedge clk);
    total++;
    if (bus.csr_we_o !== 1'b1 || bus.csr_data_o !== 64'h880) begin
      bad++;
      $display("FAIL rs_write: got we=%b data=%h want 1/880", bus.csr_we_o, bus.csr_data_o);
    end
    step();
    @(negedge clk);
    total++;
    if (bus.e_done !== 1'b1 || bus.e_rdata !== 64'h80 || bus.e_busy !== 1'b0) begin
      bad++;
      $display("FAIL rs_done: got done=%b rdata=%h busy=%b want 1/80/0", bus.e_done, bus.e_rdata, bus.e_busy);
    end
  endtask

  task automatic test_rc_zero();
    step();
    bus.e_req = 1'b1; bus.e_op = CSR_OP_RC; bus.e_addr = 12'h300; bus.e_wdata = 64'h0;
    exp_done.push_back(model_mem[int'(12'h300)]);
    step();
    idle_inputs();
    @(negedge clk);
    total++;
    if (bus.csr_we_o !== 1'b0 || bus.e_done !== 1'b0) begin
      bad++;
      $display("FAIL rc0_read: got we=%b done=%b want 0/0", bus.csr_we_o, bus.e_done);
    end
    step();
    @(negedge clk);
    total++;
    if (bus.e_done !== 1'b1 || bus.csr_we_o !== 1'b0 || bus.e_rdata !== model_mem[int'(12'h300)]) begin
      bad++;
      $display("FAIL rc0_done: got done=%b we=%b rdata=%h want 1/0/%h",
               bus.e_done, bus.csr_we_o, bus.e_rdata, model_mem[int'(12'h300)]);
    end
  endtask

  task automatic test_priority();
    logic [63:0] exp_new;
    step();
    bus.t_req = 1'b1; bus.t_lock = 1'b0; bus.t_addr = 12'h305; bus.t_wdata = 64'hFF;
    bus.e_req = 1'b1; bus.e_op = CSR_OP_RC; bus.e_addr = 12'h305; bus.e_wdata = 64'h0F;
    push_wr(12'h305, 64'hFF);
    @(negedge clk);
    total++;
    if (bus.t_gnt !== 1'b1 || bus.e_ack !== 1'b0) begin
      bad++;
      $display("FAIL prio_same: got gnt=%b ack=%b want 1/0", bus.t_gnt, bus.e_ack);
    end
    step();
    bus.t_req = 1'b0;
    @(negedge clk);
    total++;
    if (bus.e_ack !== 1'b1) begin
      bad++;
      $display("FAIL prio_ack_after: got ack=%b want 1", bus.e_ack);
    end
    exp_done.push_back(model_mem[int'(12'h305)]);
    exp_new = model_mem[int'(12'h305)] & ~64'h0F;
    step();
    bus.e_req = 1'b0;
    bus.t_req = 1'b1; bus.t_addr = 12'h306; bus.t_wdata = 64'hE0E0;
    @(negedge clk);
    total++;
    if (bus.t_gnt !== 1'b0 || bus.e_busy !== 1'b1) begin
      bad++;
      $display("FAIL prio_wait_rd: got gnt=%b busy=%b want 0/1", bus.t_gnt, bus.e_busy);
    end
    push_wr(12'h305, exp_new);
    step();
    @(negedge clk);
    total++;
    if (bus.t_gnt !== 1'b0 || bus.csr_we_o !== 1'b1 || bus.csr_data_o !== 64'hF0) begin
      bad++;
      $display("FAIL prio_wait_wr: got gnt=%b we=%b data=%h want 0/1/f0", bus.t_gnt, bus.csr_we_o, bus.csr_data_o);
    end
    push_wr(12'h306, 64'hE0E0);
    step();
    @(negedge clk);
    total++;
    if (bus.t_gnt !== 1'b1 || bus.csr_addr_o !== 12'h306 || bus.e_done !== 1'b1 || bus.e_rdata !== 64'hFF) begin
      bad++;
      $display("FAIL prio_trap_late: got gnt=%b addr=%h done=%b rdata=%h want 1/306/1/ff",
               bus.t_gnt, bus.csr_addr_o, bus.e_done, bus.e_rdata);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_flush_reset();
    step();
    bus.e_req = 1'b1; bus.e_op = CSR_OP_RW; bus.e_addr = 12'h341; bus.e_wdata = 64'h1234;
    step();
    bus.e_req = 1'b0; bus.flush_i = 1'b1;
    @(negedge clk);
    total++;
    if (bus.e_busy !== 1'b1) begin
      bad++;
      $display("FAIL flush_rd: got busy=%b want 1", bus.e_busy);
    end
    step();
    bus.flush_i = 1'b0;
    @(negedge clk);
    total++;
    if (bus.e_busy !== 1'b0 || bus.csr_we_o !== 1'b0 || bus.e_done !== 1'b0) begin
      bad++;
      $display("FAIL flush_abort: got busy=%b we=%b done=%b want 0/0/0", bus.e_busy, bus.csr_we_o, bus.e_done);
    end
    step();
    @(negedge clk);
    total++;
    if (bus.e_done !== 1'b0) begin
      bad++;
      $display("FAIL flush_nodone: got done=%b want 0", bus.e_done);
    end
    step();
    bus.e_req = 1'b1; bus.e_op = CSR_OP_RW; bus.e_addr = 12'h342; bus.e_wdata = 64'h55;
    step();
    bus.e_req = 1'b0;
    step();
    #1;
    total++;
    if (bus.csr_we_o !== 1'b1 || bus.csr_addr_o !== 12'h342) begin
      bad++;
      $display("FAIL rst_pre_wr: got we=%b addr=%h want 1/342", bus.csr_we_o, bus.csr_addr_o);
    end
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (bus.csr_we_o !== 1'b0 || bus.e_busy !== 1'b0 || bus.csr_addr_o !== 12'h000 ||
        bus.csr_data_o !== 64'h0 || bus.e_rdata !== 64'h0 || bus.e_done !== 1'b0) begin
      bad++;
      $display("FAIL rst_async: got we=%b busy=%b addr=%h data=%h rdata=%h done=%b want all 0",
               bus.csr_we_o, bus.e_busy, bus.csr_addr_o, bus.csr_data_o, bus.e_rdata, bus.e_done);
    end
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (bus.e_done !== 1'b0 || bus.csr_we_o !== 1'b0) begin
        bad++;
        $display("FAIL rst_nodone[%0d]: got done=%b we=%b want 0/0", i, bus.e_done, bus.csr_we_o);
      end
      step();
    end
  endtask

  task automatic test_ro();
    bus.e_req = 1'b1; bus.e_op = CSR_OP_RO; bus.e_addr = 12'h342; bus.e_wdata = 64'hFFFF;
    exp_done.push_back(model_mem[int'(12'h342)]);
    step();
    idle_inputs();
    step();
    @(negedge clk);
    total++;
    if (bus.e_done !== 1'b1 || bus.e_rdata !== model_mem[int'(12'h342)] || bus.csr_we_o !== 1'b0) begin
      bad++;
      $display("FAIL ro_done: got done=%b rdata=%h we=%b want 1/%h/0",
               bus.e_done, bus.e_rdata, bus.csr_we_o, model_mem[int'(12'h342)]);
    end
  endtask

  task automatic test_back_to_back();
    step();
    bus.e_req = 1'b1; bus.e_op = CSR_OP_RW; bus.e_addr = 12'h341; bus.e_wdata = 64'h11;
    exp_done.push_back(model_mem[int'(12'h341)]);
    push_wr(12'h341, 64'h11);
    step();
    bus.e_addr = 12'h300; bus.e_wdata = 64'h22;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (bus.e_ack !== 1'b0) begin
        bad++;
        $display("FAIL b2b_busy_ack[%0d]: got ack=%b want 0", i, bus.e_ack);
      end
      step();
    end
    exp_done.push_back(model_mem[int'(12'h300)]);
    push_wr(12'h300, 64'h22);
    @(negedge clk);
    total++;
    if (bus.e_ack !== 1'b1 || bus.e_done !== 1'b1 || bus.e_rdata !== 64'hA5A5_0000_0000_0341) begin
      bad++;
      $display("FAIL b2b_reaccept: got ack=%b done=%b rdata=%h want 1/1/a5a5000000000341",
               bus.e_ack, bus.e_done, bus.e_rdata);
    end
    step();
    idle_inputs();
    step();
    step();
    @(negedge clk);
    total++;
    if (bus.e_done !== 1'b1 || bus.e_rdata !== 64'hC7C7_0000_0000_0300) begin
      bad++;
      $display("FAIL b2b_done2: got done=%b rdata=%h want 1/c7c7000000000300", bus.e_done, bus.e_rdata);
    end
  endtask

`ifdef CSR_ARB_DBG_EN
  task automatic test_debug();
    bit seen_done;
    bit seen_ack;
    seen_done = 1'b0;
    seen_ack  = 1'b0;
    step();
    bus.e_req = 1'b1; bus.e_op = CSR_OP_RO; bus.e_addr = 12'h300;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'h341;
    exp_done.push_back(model_mem[int'(12'h300)]);
    @(negedge clk);
    total++;
    if (bus.e_ack !== 1'b1 || bus.d_ack !== 1'b0) begin
      bad++;
      $display("FAIL dbg_ex_first: got e_ack=%b d_ack=%b want 1/0", bus.e_ack, bus.d_ack);
    end
    step();
    bus.e_req = 1'b0;
    for (int i = 0; i < 10 && !seen_ack; i++) begin
      @(negedge clk);
      if (bus.e_done) seen_done = 1'b1;
      if (bus.d_ack) begin
        seen_ack = 1'b1;
        total++;
        if (!seen_done || bus.d_rdata !== model_mem[int'(12'h341)]) begin
          bad++;
          $display("FAIL dbg_read: got ex_done_before=%b d_rdata=%h want 1/%h",
                   seen_done, bus.d_rdata, model_mem[int'(12'h341)]);
        end
      end
      step();
    end
    bus.d_req = 1'b0;
    total++;
    if (!seen_ack) begin
      bad++;
      $display("FAIL dbg_timeout: got d_ack=0 within 10 cycles want 1");
    end
    step();
  endtask
`endif

  task automatic test_scoreboard();
    wr_t         e, a;
    logic [63:0] ed, ad;
    step();
    step();
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      total++;
      if (wr_seen.size() == 0) begin
        bad++;
        $display("FAIL sb_write: got no write want %h<=%h", e.a, e.d);
      end else begin
        a = wr_seen.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL sb_write: got %h<=%h want %h<=%h", a.a, a.d, e.a, e.d);
        end
      end
    end
    total++;
    if (wr_seen.size() != 0) begin
      bad++;
      $display("FAIL sb_extra_write: got %0d unexpected writes want 0", wr_seen.size());
    end
    while (exp_done.size() > 0) begin
      ed = exp_done.pop_front();
      total++;
      if (done_seen.size() == 0) begin
        bad++;
        $display("FAIL sb_done: got no e_done want rdata=%h", ed);
      end else begin
        ad = done_seen.pop_front();
        if (ad !== ed) begin
          bad++;
          $display("FAIL sb_done: got rdata=%h want %h", ad, ed);
        end
      end
    end
    total++;
    if (done_seen.size() != 0) begin
      bad++;
      $display("FAIL sb_extra_done: got %0d unexpected e_done want 0", done_seen.size());
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_inputs();
    test_reset();
    test_trap_burst();
    test_rs();
    test_rc_zero();
    test_priority();
    test_flush_reset();
    test_ro();
    test_back_to_back();
`ifdef CSR_ARB_DBG_EN
    test_debug();
`endif
    test_scoreboard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
